// File: rtl/lsu_pkg.sv
// Shared definitions for load_store_unit: FSM states, access-size encodings
// and the little-endian byte-lane extract/merge helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  // Move the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    ins  = (wdata << {off, 3'b000}) & mask;
    return (old & ~mask) | ins;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit bridging a CPU request port to a single-port word memory;
// sub-word stores are read-modify-write. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [MEM_ADDR_W-1:0] address,
  output logic [31:0]           data_in,
  output logic                  memRead,
  input  logic [31:0]           data_out
);

  lsu_state_e  state;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        write_r;
  logic [31:0] wdata_r;

  logic [1:0]  off_s;
  logic        mis_s;
  logic        range_err_s;
  logic        err_s;

  // Classify the incoming request and resolve the effective lane offset.
  always_comb begin
    off_s       = req_addr[1:0];
    range_err_s = ((req_addr >> MEM_ADDR_W) != 32'd0);
    case (req_size)
      SZ_HALF: mis_s = req_addr[0];
      SZ_WORD: mis_s = (req_addr[1:0] != 2'b00);
      default: mis_s = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    err_s = (req_size == SZ_BAD) | range_err_s | mis_s;
`else
    err_s = (req_size == SZ_BAD) | range_err_s;
    if (mis_s) begin
      off_s = (req_size == SZ_WORD) ? 2'b00 : {req_addr[1], 1'b0};
    end else begin
      off_s = req_addr[1:0];
    end
`endif
  end

  // Control FSM; every memory and response output is registered on entry
  // to the state that needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      memRead    <= 1'b1;
      address    <= '0;
      data_in    <= 32'd0;
      off_r      <= 2'b00;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      write_r    <= 1'b0;
      wdata_r    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            off_r     <= off_s;
            size_r    <= req_size;
            signed_r  <= req_signed;
            write_r   <= req_write;
            wdata_r   <= req_wdata;
            if (err_s) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (!req_write || (req_size != SZ_WORD)) begin
              state   <= RD;
              memRead <= 1'b1;
              address <= {req_addr[MEM_ADDR_W-1:2], 2'b00};
            end else begin
              state   <= WR;
              memRead <= 1'b0;
              address <= {req_addr[MEM_ADDR_W-1:2], 2'b00};
              data_in <= lane_merge(32'd0, req_wdata, off_s, req_size);
            end
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          if (write_r) begin
            state   <= WR;
            memRead <= 1'b0;
            data_in <= lane_merge(data_out, wdata_r, off_r, size_r);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lane_extract(data_out, off_r, size_r, signed_r);
          end
        end
        WR: begin
          state      <= RESP;
          memRead    <= 1'b1;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          memRead    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model,
// per-cycle monitor, directed scenarios and randomized traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic        memRead;
  logic [31:0] data_out;

  load_store_unit #(.MEM_ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .data_in(data_in),
    .memRead(memRead), .data_out(data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16] = '{default: 32'd0};
  logic [31:0] ref_mem [16] = '{default: 32'd0};

  assign data_out = mem[address[5:2]];

  always @(posedge clk) begin
    if (!memRead) mem[address[5:2]] <= data_in;
  end

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int acc_cnt = 0;
  int writes_seen = 0;
  int last_lat = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          acc;
    int          due;
    bit          err;
    logic [31:0] rdata;
    bit          wr;
    int          widx;
    logic [31:0] wword;
  } exp_t;

  exp_t q[$];

  // Reference behaviour from the access rules, computed byte by byte.
  function automatic exp_t model(input bit w, input logic [1:0] sz, input bit sg,
                                 input logic [31:0] a, input logic [31:0] wd, input int c);
    exp_t e;
    int n, ai, ea, bo;
    logic [31:0] v;
    e.acc = c + 1; e.due = c + 1; e.rdata = 32'd0; e.wr = 1'b0; e.widx = 0; e.wword = 32'd0;
    n = (sz == 2'd3) ? 1 : (1 << sz);
    e.err = (sz == 2'd3) || (a >= 32'd64);
    ai = int'({26'd0, a[5:0]});
`ifdef LSU_MISALIGN_TRAP_EN
    if ((ai % n) != 0) e.err = 1'b1;
`endif
    if (e.err) return e;
    ea = ai - (ai % n);
    e.widx = ea / 4;
    bo = ea % 4;
    if (w) begin
      e.wr = 1'b1;
      e.wword = ref_mem[e.widx];
      for (int b = 0; b < n; b++) e.wword[8*(bo+b) +: 8] = wd[8*b +: 8];
      e.due = c + ((n == 4) ? 2 : 3);
    end else begin
      v = 32'd0;
      for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[e.widx][8*(bo+b) +: 8];
      if (sg && n < 4 && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
      e.rdata = v;
      e.due = c + 2;
    end
    return e;
  endfunction

  // Per-cycle compare process against the reference model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_memRead", 32'(memRead), 32'd1);
      check("rst_address", 32'(address), 32'd0);
      check("rst_data_in", data_in, 32'd0);
      q.delete();
      writes_seen = 0;
    end else begin
      check("req_ready", 32'(req_ready), 32'((q.size() == 0) ? 1 : 0));
      if (!memRead) begin
        if (q.size() == 0 || !q[0].wr || q[0].err) begin
          check("spurious_write", 32'(memRead), 32'd1);
        end else begin
          check("wr_addr", 32'(address), 32'(q[0].widx * 4));
          check("wr_data", data_in, q[0].wword);
          check("wr_cycle", 32'(cyc), 32'(q[0].due - 1));
        end
        writes_seen++;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          check("spurious_resp", 32'(resp_valid), 32'd0);
        end else begin
          int mism = 0;
          check("resp_cycle", 32'(cyc), 32'(q[0].due));
          check("resp_err", 32'(resp_err), 32'(q[0].err));
          check("resp_rdata", resp_rdata, q[0].rdata);
          check("write_count", 32'(writes_seen), 32'(q[0].wr ? 1 : 0));
          if (q[0].wr) ref_mem[q[0].widx] = q[0].wword;
          for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) mism++;
          check("mem_state", 32'(mism), 32'd0);
          last_lat = cyc - q[0].acc + 1;
          last_rdata = resp_rdata;
          last_err = resp_err;
          void'(q.pop_front());
        end
        writes_seen = 0;
        resp_cnt++;
      end else if (q.size() != 0 && cyc > q[0].due) begin
        check("resp_missing", 32'(resp_valid), 32'd1);
        void'(q.pop_front());
        writes_seen = 0;
      end
      if (req_valid && req_ready) begin
        q.push_back(model(req_write, req_size, req_signed, req_addr, req_wdata, cyc));
        acc_cnt++;
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int start = resp_cnt;
    int n = 0;
    while (resp_cnt == start && n < 20) begin @(posedge clk); #1; n++; end
    if (resp_cnt == start) check("resp_timeout", 32'(resp_cnt - start), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    logic [3:0]  pat;
    int          n, resp_before, acc_before;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Word store, then read back.
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h5656_5656); wait_resp();
    check("word_store_mem", mem[1], 32'h5656_5656);
    check("word_store_lat", 32'(last_lat), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'd0); wait_resp();
    check("word_load_data", last_rdata, 32'h5656_5656);
    check("word_load_lat", 32'(last_lat), 32'd2);

    // Sub-word store into a preset word, then signed/unsigned loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hB898_9898); wait_resp();
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_0012); wait_resp();
    check("byte_store_mem", mem[2], 32'hB898_1298);
    check("byte_store_lat", 32'(last_lat), 32'd3);
    do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'd0); wait_resp();
    check("lh_signed", last_rdata, 32'hFFFF_B898);
    do_req(1'b0, 2'd0, 1'b0, 32'hB, 32'd0); wait_resp();
    check("lbu", last_rdata, 32'h0000_00B8);

    // Out-of-range and misaligned accesses.
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0); wait_resp();
    check("range_err", 32'(last_err), 32'd1);
    check("range_err_lat", 32'(last_lat), 32'd1);
    saved = mem[0];
    do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'hCAFE_F00D); wait_resp();
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_err", 32'(last_err), 32'd1);
    check("misalign_mem", mem[0], saved);
`else
    check("misalign_err", 32'(last_err), 32'd0);
    check("misalign_mem", mem[0], 32'hCAFE_F00D);
`endif

    // Reset asserted during the write strobe aborts the store.
    saved = mem[2];
    resp_before = resp_cnt;
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_0077);
    n = 0;
    while (memRead && n < 8) begin @(posedge clk); #1; n++; end
    check("wr_reached", 32'(memRead), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("abort_memRead", 32'(memRead), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_mem", mem[2], saved);
    check("abort_no_resp", 32'(resp_cnt), 32'(resp_before));

    // Back-to-back loads with req_valid held high.
    acc_before = acc_cnt;
    resp_before = resp_cnt;
    pat = 4'd0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h8;
    for (int j = 0; j < 12; j++) begin
      if (j < 4) pat[3-j] = req_ready;
      @(posedge clk); #1;
      req_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_pattern", 32'(pat), 32'h9);
    check("b2b_accepts", 32'(acc_cnt - acc_before), 32'd4);
    check("b2b_resps", 32'(resp_cnt - resp_before), 32'd4);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [1:0] sz;
      r = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 70)), $urandom);
      wait_resp();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have exactly one clock and one reset: the clock is clk and the reset is rst_n, asynchronous, active-low.
REQ-002 Parameter MEM_ADDR_W, default 6, SHALL be the byte-address width of the attached data memory (64 bytes, 16 words).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  CPU presents a request.
REQ-006 req_ready  out  1  unit accepts a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is an illegal encoding.
REQ-009 req_signed  in  1  sign-extend sub-word loads.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  load result; 0 for stores.
REQ-014 resp_err  out  1  error flag, qualified by resp_valid.
REQ-015 address  out  MEM_ADDR_W  word-aligned memory address; low 2 bits are always 0.
REQ-016 data_in  out  32  memory write data.
REQ-017 memRead  out  1  1 = read, 0 = write strobe.
REQ-018 data_out  in  32  memory read data, valid in the same cycle address is driven.

Function
REQ-019 SHALL implement the FSM states IDLE, RD, WR and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE.
- A request is accepted when req_valid and req_ready are both 1.
- The accepted request is registered on acceptance.
REQ-021 Transitions out of IDLE after acceptance SHALL be:
- error -> RESP
- load or sub-word store -> RD
- word store -> WR
REQ-022 In RD the unit SHALL drive memRead=1 and address = word address, and capture data_out into a buffer.
- Next state is WR for a store, RESP for a load.
REQ-023 In WR the unit SHALL drive memRead=0 for exactly one cycle, with data_in = buffer with the byte lanes selected by req_addr[1:0] replaced by the store data; then go to RESP.
REQ-024 memRead SHALL be 1 in every state other than WR.
REQ-025 In RESP, resp_valid SHALL be 1 for one cycle, then the FSM returns to IDLE; there is no response backpressure.
REQ-026 Latencies from the acceptance edge to the resp_valid cycle SHALL be:
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
- error: 1 cycle
REQ-027 Loads SHALL be little-endian: lane = req_addr[1:0], shifted to bit 0, then sign- or zero-extended per req_signed.
REQ-028 An error SHALL be flagged, with no memory access (memRead stays 1), for any of:
- req_size = 3
- req_addr >= 2**MEM_ADDR_W
- misalignment, subject to REQ-033
REQ-029 A new request SHALL not be accepted in the RESP cycle.
- Back-to-back throughput is therefore one request per 3 cycles minimum.

Reset
REQ-030 While rst_n = 0 the unit SHALL hold:
- state = IDLE
- req_ready = 1
- resp_valid = 0, resp_err = 0, resp_rdata = 0
- memRead = 1, address = 0, data_in = 0
REQ-031 Reset asserted mid-operation SHALL abort the operation immediately.
- No write strobe is issued and no response is produced.
- memRead returns to 1 asynchronously.
REQ-032 After reset deasserts, the unit SHALL accept a request on the first rising edge.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN SHALL control misalignment handling (halfword with addr[0]=1, or word with addr[1:0]!=0).
- Defined: a misaligned access is an error (REQ-028).
- Undefined: the offending low address bits are cleared and the access proceeds normally.

Structure
REQ-034 Package lsu_pkg SHALL hold:
- the state enum
- size encodings SZ_BYTE, SZ_HALF, SZ_WORD
- the lane-extract function
- the lane-merge function
REQ-035 The datapath SHALL be one module with no sub-modules; the FSM and lane functions are inline.

Verification
REQ-036 The bench SHALL connect the unit to a behavioral 16-word memory model and cover the following scenarios.
- Word store: addr 0x4, wdata 0x56565656 -> one memRead=0 cycle at address 4; a later word load from 0x4 returns 0x56565656.
- Sub-word store: memory word 8 = 0xB8989898; byte store 0x12 at 0x9 -> RD then WR; word 8 = 0xB8981298; resp at accept+3.
- Signed loads at 0x8 (word 8 = 0xB8981298):
  - signed halfword at 0xA -> 0xFFFFB898
  - unsigned byte at 0xB -> 0x000000B8
- Errors: word load from 0x40 -> resp_err=1 at accept+1 and memRead never 0; with LSU_MISALIGN_TRAP_EN, word store to 0x2 -> resp_err=1 and memory unchanged.
- Reset mid-operation: rst_n low during WR -> memRead=1 within the same cycle, memory unchanged, no resp_valid.
- Throughput: back-to-back loads held on req_valid -> req_ready pattern 1,0,0,1; no request lost.
